// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding and hazard detection for the pipelined rv32i core.
// A shadow scoreboard holds one entry per post-decode stage (slot 0 = EX,
// slot 1 = MEM, slot 2 = WB). For the instruction in ID the unit raises a
// combinational stall on load-use / outstanding-load hazards. It also registers
// per-source forwarding selects, so they are valid when that instruction sits in EX.
// Optional feature: define FWD_PERF_CNT_EN to build the saturating stall counter.
// Without it, stall_count is tied to zero.
module fwd_hazard_unit #(
  parameter int DEPTH = 3,
  parameter int NSRC  = 2,
  parameter int REGW  = 5,
  parameter int CNTW  = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  id_valid,
  input  logic [NSRC*REGW-1:0]                  id_rs,
  input  logic [NSRC-1:0]                       id_rs_used,
  input  logic [REGW-1:0]                       id_rd,
  input  logic                                  id_wr_reg,
  input  logic                                  id_is_load,
  input  logic                                  mem_resp,
  input  logic                                  pipe_hold,
  input  logic                                  flush,
  output logic                                  stall_id,
  output logic [NSRC*$clog2(DEPTH+1)-1:0]       fwd_sel,
  output logic [CNTW-1:0]                       stall_count
);

  localparam int SELW = $clog2(DEPTH+1);

  // Scoreboard slots, index 0 is the youngest producer.
  logic [DEPTH-1:0] slot_valid_r;
  logic [DEPTH-1:0] slot_wr_r;
  logic [DEPTH-1:0] slot_load_r;
  logic [DEPTH-1:0] slot_ready_r;
  logic [REGW-1:0]  slot_rd_r [DEPTH];

  logic [NSRC-1:0]      hazard_s;
  logic [NSRC*SELW-1:0] sel_s;
  logic                 stall_s;
  logic                 issue_s;

  // A slot produces rs when it holds a valid register writer of that index.
  // Writes to x0 are never a dependency.
  function automatic logic slot_hit(input logic v, input logic wr,
                                    input logic [REGW-1:0] rd,
                                    input logic [REGW-1:0] rs);
    return v & wr & (rd == rs) & (rs != {REGW{1'b0}});
  endfunction

  // A load's data becomes available in MEM: in slot 1 the same-cycle
  // response counts. Beyond slot 1 every entry is ready.
  function automatic logic slot_is_ready(input int k, input logic is_load,
                                         input logic rdy, input logic resp);
    logic r;
    if (k >= 2) begin
      r = 1'b1;
    end else if (k == 1) begin
      r = ~is_load | rdy | resp;
    end else begin
      r = ~is_load | rdy;
    end
    return r;
  endfunction

  // Per source: find the youngest matching producer, its readiness and the
  // forwarding select it implies once the consumer reaches EX.
  always_comb begin
    hazard_s = {NSRC{1'b0}};
    sel_s    = {(NSRC*SELW){1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      // Walk oldest to youngest so the youngest match is written last.
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (id_rs_used[i] &&
            slot_hit(slot_valid_r[k], slot_wr_r[k], slot_rd_r[k], id_rs[i*REGW +: REGW])) begin
          hazard_s[i] = ~slot_is_ready(k, slot_load_r[k], slot_ready_r[k], mem_resp);
          sel_s[i*SELW +: SELW] = (k + 1 <= DEPTH - 1) ? SELW'(k + 1) : {SELW{1'b0}};
        end else begin
          hazard_s[i] = hazard_s[i];
          sel_s[i*SELW +: SELW] = sel_s[i*SELW +: SELW];
        end
      end
    end
    stall_s = ~rst & id_valid & ~flush & (|hazard_s);
    issue_s = id_valid & ~stall_s & ~flush;
  end

  assign stall_id = stall_s;

  // Scoreboard shift, ID issue into slot 0 and registered forwarding selects.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_r <= {DEPTH{1'b0}};
      slot_wr_r    <= {DEPTH{1'b0}};
      slot_load_r  <= {DEPTH{1'b0}};
      slot_ready_r <= {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        slot_rd_r[k] <= {REGW{1'b0}};
      end
      fwd_sel <= {(NSRC*SELW){1'b0}};
    end else if (!pipe_hold) begin
      for (int k = DEPTH-1; k >= 1; k--) begin
        slot_valid_r[k] <= slot_valid_r[k-1];
        slot_wr_r[k]    <= slot_wr_r[k-1];
        slot_load_r[k]  <= slot_load_r[k-1];
        slot_rd_r[k]    <= slot_rd_r[k-1];
        // Anything leaving MEM is complete, even a load whose response never came.
        slot_ready_r[k] <= (k >= 2) ? 1'b1 : slot_ready_r[k-1];
      end
      slot_valid_r[0] <= issue_s;
      slot_wr_r[0]    <= id_wr_reg;
      slot_load_r[0]  <= id_is_load;
      slot_rd_r[0]    <= id_rd;
      slot_ready_r[0] <= ~id_is_load;
      fwd_sel         <= issue_s ? sel_s : {(NSRC*SELW){1'b0}};
    end else begin
      // Frozen pipe: a response still completes the load waiting in MEM.
      if (mem_resp && slot_valid_r[1] && slot_load_r[1]) begin
        slot_ready_r[1] <= 1'b1;
      end else begin
        slot_ready_r[1] <= slot_ready_r[1];
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [CNTW-1:0] stall_count_r;

  // Count stall cycles that actually inject a bubble; saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_r <= {CNTW{1'b0}};
    end else if (stall_s && !pipe_hold && (stall_count_r != {CNTW{1'b1}})) begin
      stall_count_r <= stall_count_r + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall_count = stall_count_r;
`else
  assign stall_count = {CNTW{1'b0}};
`endif

endmodule
